// File: rtl/crc_framer.sv
// CRC framer: MSB-first CRC insertion (MAP_MODE=1) or checking (MAP_MODE=0) on fixed-length frames.
// Define CRC_FRAMER_ERR_CNT_EN to add the saturating o_crc_err_cnt output.
module crc_framer #(
  parameter int unsigned MAP_MODE    = 1,
  parameter int unsigned FRAME_BYTES = 64,
  parameter int unsigned CRC_W       = 16,
  parameter logic [31:0] POLY        = 32'h0000_1021,
  parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_frame_data,
  input  logic        i_frame_data_valid,
  input  logic        i_frame_data_fas,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic        o_crc_err,
`ifdef CRC_FRAMER_ERR_CNT_EN
  output logic        o_locked,
  output logic [15:0] o_crc_err_cnt
`else
  output logic        o_locked
`endif
);

  localparam int unsigned CRC_BYTES = CRC_W / 8;
  localparam int unsigned LAST_CALC = FRAME_BYTES - CRC_BYTES - 1;
  localparam int unsigned IDX_W     = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  typedef enum logic [1:0] {HUNT, CALC, FIELD} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CRC_W-1:0]   crc_q;
  logic               err_acc_q;
  logic [CRC_W-1:0]   crc_shift;
  logic [7:0]         field_byte;
  logic               field_mismatch;
  int unsigned        shamt;

  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0};
      if (fb) r = r ^ POLY[CRC_W-1:0];
    end
    return r;
  endfunction

  // Byte of the CRC that belongs at the current FIELD index: last index carries the LSB.
  always_comb begin
    shamt          = 8 * (FRAME_BYTES - 1 - 32'(idx_q));
    crc_shift      = crc_q >> shamt;
    field_byte     = crc_shift[7:0];
    field_mismatch = (field_byte != i_frame_data);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q            <= HUNT;
      idx_q              <= '0;
      crc_q              <= CRC_INIT[CRC_W-1:0];
      err_acc_q          <= 1'b0;
      o_frame_data       <= 8'h00;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_crc_err          <= 1'b0;
      o_locked           <= 1'b0;
    end else begin
      o_frame_data_valid <= i_frame_data_valid;
      o_frame_data_fas   <= i_frame_data_valid & i_frame_data_fas;
      o_crc_err          <= 1'b0;
      if (i_frame_data_valid) begin
        o_frame_data <= i_frame_data;
        if (i_frame_data_fas) begin
          // FAS always (re)starts a frame, aborting any frame in progress.
          crc_q     <= crc_byte(CRC_INIT[CRC_W-1:0], i_frame_data);
          idx_q     <= IDX_W'(1);
          err_acc_q <= 1'b0;
          state_q   <= (LAST_CALC == 0) ? FIELD : CALC;
          o_locked  <= 1'b1;
        end else begin
          case (state_q)
            CALC: begin
              if (idx_q == '0) begin
                state_q  <= HUNT;
                o_locked <= 1'b0;
              end else begin
                crc_q    <= crc_byte(crc_q, i_frame_data);
                idx_q    <= idx_q + IDX_W'(1);
                o_locked <= 1'b1;
                if (idx_q == IDX_W'(LAST_CALC)) state_q <= FIELD;
              end
            end
            FIELD: begin
              o_locked <= 1'b1;
              if (MAP_MODE == 1) o_frame_data <= field_byte;
              if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                idx_q     <= '0;
                state_q   <= CALC;
                o_crc_err <= (MAP_MODE == 0) && (err_acc_q || field_mismatch);
              end else begin
                idx_q     <= idx_q + IDX_W'(1);
                err_acc_q <= err_acc_q | field_mismatch;
              end
            end
            default: begin
              state_q  <= HUNT;
              o_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef CRC_FRAMER_ERR_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_crc_err_cnt <= 16'h0000;
    end else if (o_crc_err && (o_crc_err_cnt != 16'hFFFF)) begin
      o_crc_err_cnt <= o_crc_err_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/crc_framer.md
CRC_FRAMER -- requirements
Module: crc_framer

Interface
REQ-001 Parameter MAP_MODE, default 1; 1 = compute and insert CRC, 0 = compute and check CRC.
REQ-002 Parameter FRAME_BYTES, default 64; valid bytes per frame including the CRC field, minimum CRC_W/8+1.
REQ-003 Parameter CRC_W, default 16; CRC width, legal values 8, 16 and 32.
REQ-004 Parameter POLY, default 32'h0000_1021; generator polynomial, low CRC_W bits used, implicit x^CRC_W term.
REQ-005 Parameter CRC_INIT, default 32'hFFFF_FFFF; seed, low CRC_W bits used.
REQ-006 i_clk  input  1  sole clock, all logic rising-edge.
REQ-007 i_rst  input  1  synchronous, active-high reset.
REQ-008 i_frame_data  input  8  line byte.
REQ-009 i_frame_data_valid  input  1  byte qualifier.
REQ-010 i_frame_data_fas  input  1  marks first byte of a frame, meaningful only with valid.
REQ-011 o_frame_data  output  8  line byte out, CRC field replaced when MAP_MODE=1.
REQ-012 o_frame_data_valid  output  1  delayed i_frame_data_valid.
REQ-013 o_frame_data_fas  output  1  delayed i_frame_data_fas.
REQ-014 o_crc_err  output  1  one-cycle mismatch pulse; tied 0 when MAP_MODE=1.
REQ-015 o_locked  output  1  high while the block is frame-aligned.

Function
REQ-016 All outputs SHALL be registered, latency exactly 1 cycle from input to output, one byte per valid cycle, no back-pressure.
REQ-017 Invalid cycles SHALL hold all state; o_frame_data_valid=0, o_frame_data_fas=0, o_frame_data holds its last value.
REQ-018 The FSM SHALL have states HUNT, CALC and FIELD with a byte index 0..FRAME_BYTES-1.
REQ-019 HUNT: data passes unchanged, no CRC activity, o_locked=0; a valid FAS byte moves to CALC with index 0.
REQ-020 CALC covers indices 0..FRAME_BYTES-CRC_W/8-1; FIELD covers the last CRC_W/8 indices.
REQ-021 The CRC SHALL be reseeded with CRC_INIT on every FAS byte, then updated over all CALC bytes: MSB-first, bit 7 first, no reflection, no final XOR.
REQ-022 MAP_MODE=1: FIELD bytes SHALL be replaced by the CRC, most-significant byte first; FAS and valid pass unchanged.
REQ-023 MAP_MODE=0: FIELD bytes pass unchanged and are compared with the CRC; on any mismatch o_crc_err pulses with the last FIELD byte output.
REQ-024 After index FRAME_BYTES-1 the index wraps to 0: a next valid byte carrying FAS starts a new frame; one without FAS SHALL force HUNT and pass through unmodified.
REQ-025 A FAS arriving at a nonzero index SHALL abort the current frame (no insertion, no check, no o_crc_err) and restart at index 0 with that byte.
REQ-026 o_locked SHALL be high in CALC and FIELD, low in HUNT.

Reset
REQ-027 On i_rst: FSM=HUNT, index=0, CRC=CRC_INIT, o_frame_data=0, o_frame_data_valid=0, o_frame_data_fas=0, o_crc_err=0, o_locked=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first byte after reset is treated as if in HUNT.

Configuration
REQ-029 Macro CRC_FRAMER_ERR_CNT_EN: when defined, add output o_crc_err_cnt [15:0], incremented on each o_crc_err pulse, saturating at 16'hFFFF, cleared by i_rst.
REQ-030 Without CRC_FRAMER_ERR_CNT_EN the port and counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 MAP_MODE=1, FRAME_BYTES=11, CRC_W=16, POLY=1021, INIT=FFFF; input ASCII "123456789"+00 00, FAS on byte 0 -> output bytes 9-10 = 29, B1; all others unchanged; latency 1.
REQ-032 MAP_MODE=0, same frame with field 29 B1 -> o_crc_err stays 0; field 29 B0 -> one o_crc_err pulse with the output byte B0.
REQ-033 Frame from REQ-031 with valid deasserted for 3 cycles between bytes 4 and 5 -> same 29 B1 result; output valid gaps mirror the input.
REQ-034 FAS at index 6 of frame N -> no insertion/check for frame N; the new frame from that byte produces the correct CRC.
REQ-035 Byte after frame end without FAS -> o_locked falls, data passes unmodified until the next FAS; i_rst at index 5 -> all outputs 0 next cycle, FSM=HUNT.
REQ-036 With CRC_FRAMER_ERR_CNT_EN, 3 bad frames in MAP_MODE=0 -> o_crc_err_cnt=3; preloaded to FFFF -> stays FFFF.
